// File: rtl/sprite_pkg.sv
// Shared types and reset defaults for the multi-sprite compositor.
package sprite_pkg;

  localparam int unsigned MAX_SPRITES    = 8;
  localparam int unsigned MAX_COLOR_BITS = 8;
  localparam int unsigned POS_BITS       = 8;
  localparam int unsigned X_STEP         = 16;
  localparam int unsigned Y_STEP         = 8;

  typedef enum logic [1:0] {
    FIELD_X      = 2'd0,
    FIELD_Y      = 2'd1,
    FIELD_COLOR  = 2'd2,
    FIELD_BITMAP = 2'd3
  } wr_field_t;

  typedef struct packed {
    logic                      opaque;
    logic [MAX_COLOR_BITS-1:0] color;
  } sprite_hit_t;

  // Reset colour per sprite index (rrggbb in the low bits).
  localparam logic [MAX_COLOR_BITS-1:0] DEFAULT_COLOR [MAX_SPRITES] = '{
    8'h30, 8'h0C, 8'h03, 8'h3C, 8'h33, 8'h0F, 8'h3F, 8'h2A
  };

endpackage

// File: rtl/multi_sprite_engine_if.sv
// Register-write port from the SPI receiver into the sprite engine.
interface multi_sprite_engine_if #(
  parameter int unsigned NUM_SPRITES = 4
) ();
  import sprite_pkg::*;

  localparam int unsigned SPRITE_BITS = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic                   wr_en;
  logic [SPRITE_BITS-1:0] wr_sprite;
  wr_field_t              wr_field;
  logic [7:0]             wr_data;

  modport master (output wr_en, wr_sprite, wr_field, wr_data);
  modport slave  (input  wr_en, wr_sprite, wr_field, wr_data);
endinterface

// File: rtl/sprite_unit.sv
// One sprite: shadow/active position, colour, bitmap and the per-pixel opacity lookup.
module sprite_unit
  import sprite_pkg::*;
#(
  parameter int unsigned IDX           = 0,
  parameter int unsigned SPRITE_WIDTH  = 12,
  parameter int unsigned SPRITE_HEIGHT = 12,
  parameter int unsigned CNT_BITS      = 11,
  parameter int unsigned COLOR_BITS    = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [CNT_BITS-1:0] hs,
  input  logic signed [CNT_BITS-1:0] vs,
  input  logic                       next_frame,
  input  logic                       wr_en,
  input  wr_field_t                  wr_field,
  input  logic [7:0]                 wr_data,
  output sprite_hit_t                hit_c
);

  localparam int unsigned NPIX     = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int unsigned IDX_BITS = $clog2(NPIX);
  localparam int unsigned CMP_BITS = CNT_BITS + 1;
  localparam logic signed [CMP_BITS-1:0] W_S = CMP_BITS'(SPRITE_WIDTH);
  localparam logic signed [CMP_BITS-1:0] H_S = CMP_BITS'(SPRITE_HEIGHT);

  logic [POS_BITS-1:0]   x_act, y_act, x_sh, y_sh;
  logic [POS_BITS-1:0]   x_nxt_c, y_nxt_c;
  logic [COLOR_BITS-1:0] color;
  logic [NPIX-1:0]       bitmap;

  // A position write in the same cycle as next_frame bypasses into the active copy.
  always_comb begin
    x_nxt_c = (wr_en && wr_field == FIELD_X) ? wr_data : x_sh;
    y_nxt_c = (wr_en && wr_field == FIELD_Y) ? wr_data : y_sh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_sh   <= POS_BITS'(X_STEP * IDX);
      x_act  <= POS_BITS'(X_STEP * IDX);
      y_sh   <= POS_BITS'(Y_STEP * IDX);
      y_act  <= POS_BITS'(Y_STEP * IDX);
      color  <= COLOR_BITS'(DEFAULT_COLOR[IDX]);
      bitmap <= '1;
    end else begin
      x_sh <= x_nxt_c;
      y_sh <= y_nxt_c;
      if (next_frame) begin
        x_act <= x_nxt_c;
        y_act <= y_nxt_c;
      end
      if (wr_en && wr_field == FIELD_COLOR) color <= wr_data[COLOR_BITS-1:0];
      if (wr_en && wr_field == FIELD_BITMAP) bitmap <= {bitmap[NPIX-2:0], wr_data[0]};
    end
  end

  logic signed [CMP_BITS-1:0] col_c, row_c;
  logic                       covered_c;
  logic [IDX_BITS-1:0]        pix_idx_c;

  // Offsets are taken one bit wider than the counters so negative hs/vs never match.
  always_comb begin
    col_c     = CMP_BITS'(hs) - CMP_BITS'(x_act);
    row_c     = CMP_BITS'(vs) - CMP_BITS'(y_act);
    covered_c = !col_c[CMP_BITS-1] && (col_c < W_S) && !row_c[CMP_BITS-1] && (row_c < H_S);
    pix_idx_c = '0;
    if (covered_c)
      pix_idx_c = IDX_BITS'(IDX_BITS'(row_c) * IDX_BITS'(SPRITE_WIDTH) + IDX_BITS'(col_c));
    hit_c.opaque = covered_c && bitmap[pix_idx_c];
    hit_c.color  = MAX_COLOR_BITS'(color);
  end

endmodule

// File: rtl/multi_sprite_engine.sv
// Composites NUM_SPRITES 1-bpp sprites with fixed index priority; registered pixel output.
// Optional per-frame collision flags are built when SPRITE_COLLISION_EN is defined.
module multi_sprite_engine
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES   = 4,
  parameter int unsigned SPRITE_WIDTH  = 12,
  parameter int unsigned SPRITE_HEIGHT = 12,
  parameter int unsigned SCALE_SHIFT   = 3,
  parameter int unsigned CNT_BITS      = 11,
  parameter int unsigned COLOR_BITS    = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic signed [CNT_BITS-1:0] counter_h,
  input  logic signed [CNT_BITS-1:0] counter_v,
  input  logic                       blank,
  input  logic                       next_frame,
  multi_sprite_engine_if.slave       wr,
  output logic                       pix_hit,
  output logic [COLOR_BITS-1:0]      pix_color,
  output logic [NUM_SPRITES-1:0]     collision
);

  localparam int unsigned SPRITE_BITS = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic signed [CNT_BITS-1:0] hs, vs;
  sprite_hit_t                hits [NUM_SPRITES];

  assign hs = counter_h >>> SCALE_SHIFT;
  assign vs = counter_v >>> SCALE_SHIFT;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    sprite_unit #(
      .IDX          (i),
      .SPRITE_WIDTH (SPRITE_WIDTH),
      .SPRITE_HEIGHT(SPRITE_HEIGHT),
      .CNT_BITS     (CNT_BITS),
      .COLOR_BITS   (COLOR_BITS)
    ) u_sprite (
      .clk       (clk),
      .reset_n   (reset_n),
      .hs        (hs),
      .vs        (vs),
      .next_frame(next_frame),
      .wr_en     (wr.wr_en && (wr.wr_sprite == SPRITE_BITS'(i))),
      .wr_field  (wr.wr_field),
      .wr_data   (wr.wr_data),
      .hit_c     (hits[i])
    );
  end

  logic                      win_hit_c;
  logic [MAX_COLOR_BITS-1:0] win_color_c;
  logic                      unused_win_color;

  // Walk from the highest index down so the lowest opaque index overwrites last.
  always_comb begin
    win_hit_c   = 1'b0;
    win_color_c = '0;
    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
      if (hits[i].opaque) begin
        win_hit_c   = 1'b1;
        win_color_c = hits[i].color;
      end
    end
  end

  assign unused_win_color = &{1'b0, win_color_c};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_hit   <= 1'b0;
      pix_color <= '0;
    end else begin
      pix_hit   <= win_hit_c && !blank;
      pix_color <= (win_hit_c && !blank) ? win_color_c[COLOR_BITS-1:0] : '0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] opaque_c, cur_c, acc;
  logic                   multi_c;

  // Two or more opaque sprites in a visible cycle flag all of them.
  always_comb begin
    opaque_c = '0;
    for (int i = 0; i < int'(NUM_SPRITES); i++) opaque_c[i] = hits[i].opaque;
    multi_c = |(opaque_c & (opaque_c - NUM_SPRITES'(1)));
    cur_c   = (multi_c && !blank) ? opaque_c : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      collision <= '0;
    end else if (next_frame) begin
      collision <= acc | cur_c;
      acc       <= '0;
    end else begin
      acc <= acc | cur_c;
    end
  end
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Randomized bench for multi_sprite_engine against a behavioural sprite model.
module tb_multi_sprite_engine;
  import sprite_pkg::*;

  localparam int NS   = 4;
  localparam int W    = 12;
  localparam int H    = 12;
  localparam int NPIX = W * H;
  localparam logic [5:0] DEF_COL [NS] = '{6'h30, 6'h0C, 6'h03, 6'h3C};

  logic clk = 1'b0;
  logic reset_n;
  logic signed [10:0] counter_h, counter_v;
  logic blank, next_frame;
  logic pix_hit;
  logic [5:0] pix_color;
  logic [3:0] collision;

  always #5 clk = ~clk;

  multi_sprite_engine_if #(.NUM_SPRITES(NS)) wr_if ();

  multi_sprite_engine #(
    .NUM_SPRITES(NS), .SPRITE_WIDTH(W), .SPRITE_HEIGHT(H),
    .SCALE_SHIFT(3), .CNT_BITS(11), .COLOR_BITS(6)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .counter_h (counter_h),
    .counter_v (counter_v),
    .blank     (blank),
    .next_frame(next_frame),
    .wr        (wr_if.slave),
    .pix_hit   (pix_hit),
    .pix_color (pix_color),
    .collision (collision)
  );

  // Behavioural model state
  int             m_xa [NS], m_ya [NS], m_xs [NS], m_ys [NS];
  logic [5:0]     m_col [NS];
  bit [NPIX-1:0]  m_bm [NS];
  logic [3:0]     m_acc, m_coll;
  int             n_pass = 0, n_checks = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_xa[i] = 16 * i; m_xs[i] = 16 * i;
      m_ya[i] = 8 * i;  m_ys[i] = 8 * i;
      m_col[i] = DEF_COL[i];
      m_bm[i]  = '1;
    end
    m_acc  = '0;
    m_coll = '0;
  endfunction

  function automatic bit opaque(input int i, input int hs, input int vs);
    int c, r;
    c = hs - m_xa[i];
    r = vs - m_ya[i];
    if (c < 0 || c >= W || r < 0 || r >= H) return 1'b0;
    return m_bm[i][r * W + c];
  endfunction

  // One pixel clock: drive, predict from pre-edge model state, update model, compare.
  task automatic step(input int ch, input int cv, input bit bl, input bit nf,
                      input bit we, input int ws, input int wf, input int wd);
    int hs, vs, cnt;
    bit found;
    logic [5:0] wcol;
    logic [3:0] cur;
    bit exp_hit;
    logic [5:0] exp_color;
    @(negedge clk);
    counter_h = 11'(ch);
    counter_v = 11'(cv);
    blank = bl;
    next_frame = nf;
    wr_if.wr_en = we;
    wr_if.wr_sprite = 2'(ws);
    wr_if.wr_field = wr_field_t'(2'(wf));
    wr_if.wr_data = 8'(wd);

    hs = ch >>> 3;
    vs = cv >>> 3;
    found = 1'b0; wcol = '0; cur = '0; cnt = 0;
    for (int i = 0; i < NS; i++) begin
      if (opaque(i, hs, vs)) begin
        if (!found) begin found = 1'b1; wcol = m_col[i]; end
        cur[i] = 1'b1;
        cnt++;
      end
    end
    exp_hit   = found && !bl;
    exp_color = exp_hit ? wcol : 6'h00;
    if (bl || cnt < 2) cur = '0;
    if (nf) begin m_coll = m_acc | cur; m_acc = '0; end
    else m_acc = m_acc | cur;

    if (we && ws < NS) begin
      case (wf)
        0: m_xs[ws] = wd & 8'hFF;
        1: m_ys[ws] = wd & 8'hFF;
        2: m_col[ws] = 6'(wd);
        default: m_bm[ws] = {m_bm[ws][NPIX-2:0], 1'(wd & 1)};
      endcase
    end
    if (nf) for (int i = 0; i < NS; i++) begin m_xa[i] = m_xs[i]; m_ya[i] = m_ys[i]; end

    @(posedge clk);
    #1;
    check("pix_hit", int'(pix_hit), int'(exp_hit));
    check("pix_color", int'(pix_color), int'(exp_color));
`ifdef SPRITE_COLLISION_EN
    check("collision", int'(collision), int'(m_coll));
`else
    check("collision", int'(collision), 0);
`endif
  endtask

  task automatic wr(input int ws, input int wf, input int wd);
    step(0, 0, 1'b1, 1'b0, 1'b1, ws, wf, wd);
  endtask

  task automatic frame();
    step(0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic px(input int ch, input int cv);
    step(ch, cv, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_if.wr_en = 1'b0; blank = 1'b1; next_frame = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_pix_hit", int'(pix_hit), 0);
    check("rst_pix_color", int'(pix_color), 0);
    check("rst_collision", int'(collision), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    counter_h = '0; counter_v = '0; blank = 1'b1; next_frame = 1'b0;
    wr_if.wr_en = 1'b0; wr_if.wr_sprite = '0; wr_if.wr_field = FIELD_X; wr_if.wr_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_pix_hit", int'(pix_hit), 0);
    check("reset_collision", int'(collision), 0);
    reset_n = 1'b1;

    // Reset defaults and negative counters
    px(0, 0);
    check("lit_default_hit", int'(pix_hit), 1);
    check("lit_default_color", int'(pix_color), 'h30);
    px(-8, 0);
    check("lit_negative_h", int'(pix_hit), 0);

    // Priority between overlapping sprites 0 and 1
    wr(0, 0, 20); wr(0, 1, 20); wr(1, 0, 20); wr(1, 1, 20);
    wr(0, 2, 'h30); wr(1, 2, 'h0C);
    frame();
    px(160, 160);
    check("lit_prio_s0", int'(pix_color), 'h30);
    for (int k = 0; k < NPIX; k++) wr(0, 3, 0);
    px(160, 160);
    check("lit_prio_s1", int'(pix_color), 'h0C);

    // Frame-synchronous move of sprite 2
    wr(2, 0, 50);
    px(400, 128);
    check("lit_move_pending", int'(pix_hit), 0);
    frame();
    px(400, 128);
    check("lit_move_done", int'(pix_color), 'h03);
    step(0, 0, 1'b1, 1'b1, 1'b1, 2, 0, 60);
    px(480, 128);
    check("lit_move_bypass", int'(pix_hit), 1);

    // Bitmap load: single opaque pixel at row 11, col 11
    wr(2, 3, 1);
    for (int k = 1; k < NPIX; k++) wr(2, 3, 0);
    px(568, 216);
    check("lit_bm_last", int'(pix_hit), 1);
    px(480, 128);
    check("lit_bm_first", int'(pix_hit), 0);
    step(568, 216, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    check("lit_bm_blank", int'(pix_hit), 0);

    // Sprites 1 and 3 overlap at a single small pixel (31,31)
    wr(3, 0, 31); wr(3, 1, 31);
    frame();
    px(248, 248);
    check("lit_overlap_color", int'(pix_color), 'h0C);
    frame();
`ifdef SPRITE_COLLISION_EN
    check("lit_collision", int'(collision), 'b1010);
`else
    check("lit_collision", int'(collision), 0);
`endif
    frame();
    check("lit_collision_clear", int'(collision), 0);

    // Reset in the middle of a bitmap load
    for (int k = 0; k < 30; k++) wr(3, 3, 0);
    do_reset();
    px(88, 88);
    check("lit_reset_bm_s0", int'(pix_color), 'h30);
    px(384, 192);
    check("lit_reset_bm_s3", int'(pix_color), 'h3C);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int ch, cv, wf, wd;
      ch = (int'($urandom_range(0, 85)) - 4) * 8 + int'($urandom_range(0, 7));
      cv = (int'($urandom_range(0, 66)) - 4) * 8 + int'($urandom_range(0, 7));
      wf = int'($urandom_range(0, 3));
      wd = (wf < 2) ? int'($urandom_range(0, 70)) : int'($urandom_range(0, 255));
      step(ch, cv, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)), wf, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_sprite_engine.md
# multi_sprite_engine

Parametrised successor to the single-sprite renderer: composites `NUM_SPRITES` independent 1-bpp sprites over the background on the downscaled pixel grid. It has per-sprite colour, fixed index priority, frame-synchronous position updates and optional per-frame collision flags. It sits between the horizontal/vertical timing generators and the final colour mux. It is driven by a register-write port from the SPI receiver.

## Interface
- `NUM_SPRITES`, 4, number of sprites; must be 1..8.
- `SPRITE_WIDTH`, 12, sprite width in small pixels.
- `SPRITE_HEIGHT`, 12, sprite height in small pixels.
- `SCALE_SHIFT`, 3, log2 of the downscale factor; 3 means one small pixel is 8x8 screen pixels.
- `CNT_BITS`, 11, width of the signed timing counters.
- `COLOR_BITS`, 6, width of the colour output (rrggbb).
- `clk`, input, 1, pixel clock; one clock domain only.
- `reset_n`, input, 1, asynchronous active-low reset.
- `counter_h`, input, `CNT_BITS`, signed horizontal counter; negative values fall in blanking.
- `counter_v`, input, `CNT_BITS`, signed vertical counter.
- `blank`, input, 1, asserted during hblank or vblank.
- `next_frame`, input, 1, single-cycle end-of-frame strobe.
- `wr_en`, input, 1, register write strobe.
- `wr_sprite`, input, `$clog2(NUM_SPRITES)` (minimum 1), target sprite index.
- `wr_field`, input, 2, field select: 0 = X, 1 = Y, 2 = COLOR, 3 = BITMAP.
- `wr_data`, input, 8, write data.
- `pix_hit`, output, 1, at least one opaque sprite pixel at the current position.
- `pix_color`, output, `COLOR_BITS`, colour of the winning sprite.
- `collision`, output, `NUM_SPRITES`, per-sprite collision flags for the previous frame.

## Operation
- Small coordinates: `hs = counter_h >>> SCALE_SHIFT`, `vs = counter_v >>> SCALE_SHIFT`. The shift is arithmetic, so negative counters stay negative.
- Each sprite holds the following registers:
  - `x_act`, `y_act` (8 bit) and shadows `x_sh`, `y_sh`.
  - `color`.
  - `bitmap[SPRITE_HEIGHT*SPRITE_WIDTH]`.
- Sprite i covers pixel (hs, vs) iff all of the following hold:
  - hs ≥ x_act and hs < x_act + SPRITE_WIDTH;
  - vs ≥ y_act and vs < y_act + SPRITE_HEIGHT;
  - the compare is signed, one bit wider than the counters, so a negative hs never matches.
- Opacity index: `row = vs - y_act`, `col = hs - x_act`. Sprite i is opaque iff it covers the pixel and `bitmap[row*SPRITE_WIDTH + col]` = 1.
- Priority: the lowest index opaque sprite wins. If no sprite is opaque, `pix_hit` = 0 and `pix_color` = 0. If `blank` = 1, both are forced to 0.
- Writes, with `wr_sprite` ≥ `NUM_SPRITES` ignored:
  - X or Y: writes the shadow register only. Shadows copy to the active registers on `next_frame`.
  - COLOR: writes `wr_data[COLOR_BITS-1:0]`, effective immediately.
  - BITMAP: shifts `wr_data[0]` into `bitmap[0]`; each bit moves from `bitmap[k]` to `bitmap[k+1]`. After `SPRITE_WIDTH*SPRITE_HEIGHT` writes, the first bit written sits at the last index.
- A write and `next_frame` in the same cycle: the shadow takes the new value, and the active register takes the new value too. The write bypasses into the active register.
- Reset values:
  - `x_sh`, `x_act` = 16·i; `y_sh`, `y_act` = 8·i.
  - `color` = index-dependent default from the package.
  - `bitmap` = all ones.
  - All outputs 0. `collision` = 0.
- Reset asserted mid-frame or mid bitmap load restores all of the above at once. A partial load is lost.

## Timing
- `pix_hit` and `pix_color` are registered: 1-cycle latency from `counter_h`, `counter_v` and `blank`.
- Register writes affect the pixel computed in the next cycle.
- `collision` updates in the cycle after `next_frame` and holds for one frame.
- Active position changes only at the frame boundary, so there is no tearing within a frame.

## Configuration
- `SPRITE_COLLISION_EN` defined:
  - During any cycle with `blank` = 0 and two or more sprites opaque, every opaque sprite's bit is OR-ed into an accumulator.
  - On `next_frame`: `collision <= acc | current` and the accumulator clears. The OR with `current` covers a collision coincident with `next_frame`.
- `SPRITE_COLLISION_EN` undefined: no accumulator logic; `collision` is tied to 0.

## Structure
- Package `sprite_pkg` holds:
  - the `wr_field_t` enum (FIELD_X, FIELD_Y, FIELD_COLOR, FIELD_BITMAP);
  - the default colour array and default position constants;
  - the `sprite_hit_t` struct {opaque, color}.
- Sub-module `sprite_unit`, one instance per sprite via `generate`, contains:
  - that sprite's registers and shadow/active logic;
  - the coverage compare and the bitmap lookup, producing an opaque/colour pair.
- The top module contains the priority encoder, the output register and the collision accumulator.

## Test plan
- Reset defaults: after reset, sprite 0 covers hs 0..11, vs 0..11. Counter (0,0) → one cycle later `pix_hit` = 1 and `pix_color` = default colour 0.
- Priority: sprites 0 and 1 both at (20,20), colours 0x30 and 0x0C → `pix_color` = 0x30. Clear sprite 0's bitmap → `pix_color` = 0x0C.
- Frame-synchronous move: write X = 50 to sprite 2 mid-frame → coverage unchanged until `next_frame`, then hs 50..61 hit. A write coincident with `next_frame` takes effect immediately.
- Bitmap load: shift in 144 bits, a 1 followed by 143 zeros → only row 11, col 11 is opaque. `blank` = 1 over that pixel → `pix_hit` = 0.
- Collision (macro defined): sprites 1 and 3 overlap one opaque pixel → after `next_frame`, `collision` = 4'b1010. No overlap in the next frame → 4'b0000. With the macro undefined → always 0.
- Negative counters: `counter_h` = -8 with a sprite at x = 0 → no hit. Reset asserted mid-load → bitmap all ones again.
